// File: rtl/tdm_demux18_if.sv
// -----------------------------------------------------------------------------
// tdm_demux18_if
// Bundle of the serial TDM link signals and the published-frame outputs of
// the 1-to-8 TDM demultiplexer.
//   in, valid, sync        : serial beat from the link (driven by master)
//   out0..out7             : last complete frame, channel 0..7
//   sel                    : channel slot the next non-sync beat fills
//   locked                 : frame alignment established and intact
//   done / err             : one-cycle frame-published / framing-error pulses
// Modports: master = link side (drives beats, observes frame),
//           slave  = demultiplexer side.
// -----------------------------------------------------------------------------
interface tdm_demux18_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic             valid;
    logic             sync;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;
    logic [WIDTH-1:0] out6;
    logic [WIDTH-1:0] out7;
    logic [2:0]       sel;
    logic             locked;
    logic             done;
    logic             err;

    modport master (
        output in, valid, sync,
        input  out0, out1, out2, out3, out4, out5, out6, out7,
        input  sel, locked, done, err
    );

    modport slave (
        input  in, valid, sync,
        output out0, out1, out2, out3, out4, out5, out6, out7,
        output sel, locked, done, err
    );
endinterface

// File: rtl/tdm_demux18.sv
// -----------------------------------------------------------------------------
// tdm_demux18
// Receive end of an 8-channel serial TDM link. Each accepted beat is steered
// into a staging slot chosen by a channel counter that a sync beat aligns to
// channel 0. When the channel-7 beat arrives the whole frame is published on
// out0..out7 in one cycle and done pulses; framing faults pulse err.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high (clears frame, staging and flags)
//   bus  : tdm_demux18_if.slave -- beat inputs and published-frame outputs
// -----------------------------------------------------------------------------
module tdm_demux18 #(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    tdm_demux18_if.slave  bus
);

    // Channels 0..6 wait here; channel 7 goes straight from the link to out7,
    // so a slot for it is not needed.
    logic [WIDTH-1:0] stage [0:6];
    logic [WIDTH-1:0] frame [0:7];
    logic [2:0]       sel_q;
    logic             locked_q;
    logic             done_q;
    logic             err_q;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the staging array is cleared explicitly on reset because an
            // aborted partial frame must not survive a reset; this keeps the
            // array in flops rather than a RAM macro, which is fine at 7 words.
            for (int i = 0; i < 7; i++) stage[i] <= '0;
            for (int i = 0; i < 8; i++) frame[i] <= '0;
            sel_q    <= 3'd0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.valid) begin
                if (bus.sync) begin
                    // A sync always starts a new frame; if one was in flight it
                    // is abandoned (its staged slots are simply overwritten later).
                    if (locked_q && (sel_q != 3'd0)) err_q <= 1'b1;
                    stage[0] <= bus.in;
                    sel_q    <= 3'd1;
                    locked_q <= 1'b1;
                end else if (locked_q) begin
                    if (sel_q == 3'd0) begin
                        // Expected a sync here: drop alignment and hunt again.
                        err_q    <= 1'b1;
                        locked_q <= 1'b0;
                    end else if (sel_q == 3'd7) begin
                        for (int i = 0; i < 7; i++) frame[i] <= stage[i];
                        frame[7] <= bus.in;
                        done_q   <= 1'b1;
                        sel_q    <= 3'd0;
                    end else begin
                        for (int i = 1; i < 7; i++) begin
                            if (sel_q == 3'(i)) stage[i] <= bus.in;
                        end
                        sel_q <= sel_q + 3'd1;
                    end
                end
                // Unlocked non-sync beats are dropped while hunting for sync.
            end
        end
    end

    assign bus.out0   = frame[0];
    assign bus.out1   = frame[1];
    assign bus.out2   = frame[2];
    assign bus.out3   = frame[3];
    assign bus.out4   = frame[4];
    assign bus.out5   = frame[5];
    assign bus.out6   = frame[6];
    assign bus.out7   = frame[7];
    assign bus.sel    = sel_q;
    assign bus.locked = locked_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: doc/tdm_demux18.md
Name: tdm_demux18

Overview:
- Time-division 1-to-8 demultiplexer. It is the receive end of a serial 8-channel TDM link whose transmit end is our 8:1 selector.
- One WIDTH-bit word arrives per accepted beat.
- Beats are steered into eight channel slots by an internal channel counter that is aligned by a frame sync marker.
- Once all 8 slots of a frame are captured, the frame is published on registered outputs out0..out7 and a one-cycle done pulse is raised.
- Sits between the serial link and the per-channel consumers.

Parameters:
- WIDTH, 1, data width of each channel word (in, out0..out7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  WIDTH  serial channel word.
- valid  input  1  in/sync qualify this cycle (beat accepted when high).
- sync  input  1  marks the beat carrying channel 0 of a frame; ignored when valid=0.
- out0..out7  output  WIDTH each  registered published frame, channel 0..7.
- sel  output  3  channel index the next non-sync beat will be written to (= internal counter).
- locked  output  1  high once a sync has been seen and framing is intact.
- done  output  1  one-cycle pulse: out0..out7 updated with a complete frame.
- err  output  1  one-cycle pulse: framing error detected.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: out0..out7=0, staging regs=0, sel=0, locked=0, done=0, err=0. This applies mid-frame too: a partial frame is discarded and outputs are cleared.
- done and err default to 0 every cycle. They are high only in the cycle after the triggering beat.
- valid=0: no state change except done/err returning to 0.
- valid=1, sync=1:
  - stage[0]<=in, sel<=1, locked<=1.
  - If locked=1 and sel!=0 (sync mid-frame): err<=1. Slots 1..sel-1 of the aborted frame are discarded and not published. The new frame starts from this beat.
- valid=1, sync=0, locked=0: beat dropped, no change, no err (hunting for sync).
- valid=1, sync=0, locked=1, sel=0: expected sync missing.
  - err<=1, locked<=0, beat dropped, sel stays 0.
- valid=1, sync=0, locked=1, 1<=sel<=6: stage[sel]<=in, sel<=sel+1.
- valid=1, sync=0, locked=1, sel=7 (frame completes):
  - out0..out6 <= stage[0..6], out7 <= in.
  - done<=1, sel<=0 (wraps).
- Latency: outputs and done change in the cycle after the channel-7 beat. Between publications, outputs hold the last published frame.
- Back-to-back frames: a sync beat may immediately follow a channel-7 beat with no gap. Gaps (valid=0) may appear anywhere within a frame without affecting it.
- A sync beat whose value is accepted as channel 0 is never itself an error.
- sel is a 3-bit counter. Only the explicit wrap from 7 to 0 occurs; there is no overflow path.

Test Plan:
- Reset, then sync beat + 7 beats with in=1,0,1,1,0,0,1,0 (WIDTH=1), valid continuous -> done pulses exactly once, the cycle after the 8th beat; out0..out7 = 1,0,1,1,0,0,1,0; sel=0; err never high.
- WIDTH=8: two back-to-back frames, frame A = 8'h10..8'h17, frame B = 8'h20..8'h27, with valid low for 3 random cycles inside B -> outputs show A after its 8th beat and hold A through B's gaps; then outputs show B; two done pulses total.
- Before any sync, 5 beats with valid=1, sync=0 -> locked=0, sel=0, no done, no err, outputs stay 0; the following sync sets locked=1 the next cycle.
- Locked, frame in progress at sel=4, then sync beat with in=8'hAA -> err pulse; sel=1; completing 7 more beats publishes out0=8'hAA; the aborted partial frame is never visible on the outputs.
- After a completed frame, next beat valid=1, sync=0 -> err pulse, locked=0, outputs unchanged; data ignored until the next sync.
- Assert rst for one cycle at sel=5 -> next cycle all outputs 0, sel=0, locked=0; a subsequent full frame publishes correctly.
